// File: rtl/memory_game_checker.sv
// rtl/memory_game_checker.sv - player-side sequence checker for the memory game
//
// Buffers one round of 4-bit patterns from the pattern generator over a
// valid/ready handshake, then compares each player key entry against the
// buffered sequence in order. It tracks the round length, the score and the
// remaining lives, and reports hit/miss/round-win pulses and a game-over level.
//
// Ports:
//   CLK         rising-edge clock
//   RST         asynchronous active-high reset
//   start       begin/restart game (sampled in IDLE and OVER only)
//   pat_valid   generator presents pat_data
//   pat_data    [3:0] pattern from generator
//   pat_ready   checker accepts a pattern this cycle
//   key_valid   one-cycle player entry strobe
//   key_data    [3:0] player entry
//   hit         1-cycle pulse, correct entry
//   miss        1-cycle pulse, wrong entry (or timeout)
//   round_win   1-cycle pulse, full sequence matched
//   game_over   level, high in OVER
//   round_len   [3:0] patterns in current round
//   score       [7:0] rounds won, saturating at 255
//   lives_left  [1:0] remaining lives
//
// Optional feature: define MEMORY_GAME_TIMEOUT_EN to add a per-key idle timer
// in PLAY; TIMEOUT_CYCLES idle cycles count as a wrong entry.

module memory_game_checker #(
    parameter int MAX_LEN        = 8,
    parameter int LIVES          = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       pat_valid,
    input  logic [3:0] pat_data,
    output logic       pat_ready,
    input  logic       key_valid,
    input  logic [3:0] key_data,
    output logic       hit,
    output logic       miss,
    output logic       round_win,
    output logic       game_over,
    output logic [3:0] round_len,
    output logic [7:0] score,
    output logic [1:0] lives_left
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    localparam int         PTR_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [3:0] LEN_MAX    = 4'(MAX_LEN);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    logic [1:0]       state_q;
    logic [3:0]       pat_buf [0:MAX_LEN-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic pat_xfer;
    logic load_last;
    logic key_match;
    logic play_last;
    logic timeout;

    // A transfer only happens in LOAD; pat_ready is never high elsewhere but the
    // state term keeps the buffer write obviously confined to LOAD.
    assign pat_xfer  = (state_q == ST_LOAD) && pat_valid && pat_ready;
    assign load_last = (4'(wr_ptr) == (round_len - 4'd1));
    assign key_match = (key_data == pat_buf[rd_ptr]);
    assign play_last = (4'(rd_ptr) == (round_len - 4'd1));

`ifdef MEMORY_GAME_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] timer_q;

    // The timer idles at zero outside PLAY, so it starts from zero on entry.
    assign timeout = (state_q == ST_PLAY) && !key_valid &&
                     (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timer_q <= '0;
        end else if ((state_q != ST_PLAY) || key_valid || timeout) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Pattern storage carries no reset; only entries written this round are read.
    always_ff @(posedge CLK) begin
        if (pat_xfer) begin
            pat_buf[wr_ptr] <= pat_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            pat_ready  <= 1'b0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            round_win  <= 1'b0;
            game_over  <= 1'b0;
            round_len  <= 4'd1;
            score      <= 8'd0;
            lives_left <= LIVES_INIT;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            hit       <= 1'b0;
            miss      <= 1'b0;
            round_win <= 1'b0;

            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state_q    <= ST_LOAD;
                        pat_ready  <= 1'b1;
                        game_over  <= 1'b0;
                        round_len  <= 4'd1;
                        score      <= 8'd0;
                        lives_left <= LIVES_INIT;
                        wr_ptr     <= '0;
                    end
                end

                ST_LOAD: begin
                    if (pat_xfer) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (load_last) begin
                            pat_ready <= 1'b0;
                            state_q   <= ST_PLAY;
                            rd_ptr    <= '0;
                        end
                    end
                end

                ST_PLAY: begin
                    if (key_valid && key_match) begin
                        hit <= 1'b1;
                        if (play_last) begin
                            round_win <= 1'b1;
                            if (score != 8'hFF) begin
                                score <= score + 8'd1;
                            end
                            if (round_len < LEN_MAX) begin
                                round_len <= round_len + 4'd1;
                            end
                            wr_ptr    <= '0;
                            pat_ready <= 1'b1;
                            state_q   <= ST_LOAD;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end else if (key_valid || timeout) begin
                        // Wrong key and idle timeout cost a life the same way.
                        miss       <= 1'b1;
                        lives_left <= lives_left - 2'd1;
                        if (lives_left == 2'd1) begin
                            game_over <= 1'b1;
                            state_q   <= ST_OVER;
                        end else begin
                            wr_ptr    <= '0;
                            pat_ready <= 1'b1;
                            state_q   <= ST_LOAD;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_game_checker.sv
// tb/tb_memory_game_checker.sv - scoreboard testbench for memory_game_checker
`timescale 1ns/1ps

module tb_memory_game_checker;

    localparam int MAX_LEN = 8;
    localparam int LIVES   = 3;
`ifdef MEMORY_GAME_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic       pat_valid = 1'b0;
    logic [3:0] pat_data = 4'd0;
    logic       pat_ready;
    logic       key_valid = 1'b0;
    logic [3:0] key_data = 4'd0;
    logic       hit, miss, round_win, game_over;
    logic [3:0] round_len;
    logic [7:0] score;
    logic [1:0] lives_left;

    memory_game_checker #(
        .MAX_LEN(MAX_LEN), .LIVES(LIVES), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start),
        .pat_valid(pat_valid), .pat_data(pat_data), .pat_ready(pat_ready),
        .key_valid(key_valid), .key_data(key_data),
        .hit(hit), .miss(miss), .round_win(round_win), .game_over(game_over),
        .round_len(round_len), .score(score), .lives_left(lives_left)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       hit;
        logic       miss;
        logic       win;
        logic       over;
        logic [7:0] score;
        logic [3:0] len;
        logic [1:0] lives;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] fixed_q[$];
    logic [3:0] m_pats[$];
    int         m_len, m_score, m_lives, m_idx;
    bit         m_play, m_over;
    int         total = 0;
    int         bad = 0;

    // Monitor: every pulse cycle must match the oldest expected result.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!RST && (hit || miss || round_win)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got hit=%0b miss=%0b win=%0b, required no pulse",
                         hit, miss, round_win);
            end else begin
                e = exp_q.pop_front();
                if ({hit, miss, round_win, game_over, score, round_len, lives_left} !== e) begin
                    bad++;
                    $display("FAIL pulse: got hit=%0b miss=%0b win=%0b over=%0b score=%0d len=%0d lives=%0d, required hit=%0b miss=%0b win=%0b over=%0b score=%0d len=%0d lives=%0d",
                             hit, miss, round_win, game_over, score, round_len, lives_left,
                             e.hit, e.miss, e.win, e.over, e.score, e.len, e.lives);
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_start();
        m_len   = 1;
        m_score = 0;
        m_lives = LIVES;
        m_over  = 0;
        m_play  = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        model_start();
        @(negedge CLK);
        chk("start_game_over", game_over, 0);
        chk("start_score", score, 0);
        chk("start_lives", lives_left, LIVES);
        chk("start_round_len", round_len, 1);
        chk("start_pat_ready", pat_ready, 1);
        step();
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 40) begin
            @(negedge CLK);
            w++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending results, required 0", exp_q.size());
            exp_q.delete();
        end
        step();
    endtask

    // Generator side: supplies m_len patterns with random stalls; stray keys
    // during LOAD must not produce any pulse.
    task automatic load_round();
        int w;
        m_pats.delete();
        for (int i = 0; i < m_len; i++) begin
            int stall = $urandom_range(0, 2);
            repeat (stall) begin
                pat_valid = 1'b0;
                key_valid = 1'($urandom_range(0, 1));
                key_data  = 4'($urandom);
                @(negedge CLK);
                chk("stall_pat_ready", pat_ready, 1);
                chk("stall_round_len", round_len, m_len);
                step();
            end
            key_valid = 1'b0;
            pat_valid = 1'b1;
            if (fixed_q.size() != 0) pat_data = fixed_q.pop_front();
            else pat_data = 4'($urandom);
            w = 0;
            @(negedge CLK);
            while (!pat_ready && w < 50) begin
                @(negedge CLK);
                w++;
            end
            if (!pat_ready) begin
                $display("FAIL load_handshake: pat_ready never asserted");
                $fatal(1);
            end
            m_pats.push_back(pat_data);
            step();
        end
        pat_valid = 1'b0;
        @(negedge CLK);
        chk("ready_drop", pat_ready, 0);
        chk("play_round_len", round_len, m_len);
        chk("play_lives", lives_left, m_lives);
        chk("play_score", score, m_score);
        m_idx  = 0;
        m_play = 1;
        step();
    endtask

    task automatic fill(inout exp_t e);
        e.over  = m_over;
        e.score = 8'(m_score);
        e.len   = 4'(m_len);
        e.lives = 2'(m_lives);
    endtask

    task automatic lose_life(inout exp_t e);
        e.miss = 1'b1;
        m_lives--;
        m_play = 0;
        if (m_lives == 0) m_over = 1;
    endtask

    task automatic send_key(input logic [3:0] k);
        exp_t e;
        e = '0;
        if (k == m_pats[m_idx]) begin
            e.hit = 1'b1;
            if (m_idx == m_len - 1) begin
                e.win = 1'b1;
                if (m_score < 255) m_score++;
                if (m_len < MAX_LEN) m_len++;
                m_play = 0;
            end else begin
                m_idx++;
            end
        end else begin
            lose_life(e);
        end
        fill(e);
        exp_q.push_back(e);
        key_valid = 1'b1;
        key_data  = k;
        step();
        key_valid = 1'b0;
    endtask

    task automatic play_round(input int pct_wrong);
        logic [3:0] k;
        while (m_play) begin
            k = m_pats[m_idx];
            if ($urandom_range(0, 99) < pct_wrong) k = k ^ 4'($urandom_range(1, 15));
            send_key(k);
            if (m_play) begin
                repeat ($urandom_range(0, 2)) step();
            end
        end
        wait_drain();
    endtask

    initial begin : main
        int rounds;

        // Reset state
        step();
        chk("rst_pat_ready", pat_ready, 0);
        chk("rst_pulses", {hit, miss, round_win}, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_round_len", round_len, 1);
        chk("rst_score", score, 0);
        chk("rst_lives", lives_left, LIVES);
        RST = 1'b0;
        step();

        // Keys and patterns in IDLE are ignored
        key_valid = 1'b1; pat_valid = 1'b1; key_data = 4'h5;
        step();
        key_valid = 1'b0; pat_valid = 1'b0;
        repeat (3) step();
        @(negedge CLK);
        chk("idle_pat_ready", pat_ready, 0);
        step();

        // Single pattern round won
        do_start();
        fixed_q = '{4'hA};
        load_round();
        send_key(4'hA);
        wait_drain();
        @(negedge CLK);
        chk("after_win_pat_ready", pat_ready, 1);
        chk("after_win_round_len", round_len, 2);
        step();

        // Two-pattern round: hit then miss
        fixed_q = '{4'h3, 4'hC};
        load_round();
        send_key(4'h3);
        send_key(4'h5);
        wait_drain();
        @(negedge CLK);
        chk("after_miss_lives", lives_left, 2);
        chk("after_miss_round_len", round_len, 2);
        chk("after_miss_pat_ready", pat_ready, 1);
        step();

        // Random play until game over
        rounds = 0;
        while (!m_over && rounds < 60) begin
            load_round();
            play_round(rounds < 20 ? 25 : 100);
            rounds++;
        end
        @(negedge CLK);
        chk("over_game_over", game_over, 1);
        chk("over_lives", lives_left, 0);
        step();
        key_valid = 1'b1; key_data = 4'($urandom);
        step();
        key_valid = 1'b0;
        repeat (3) step();
        @(negedge CLK);
        chk("over_hold_score", score, m_score);
        chk("over_hold_len", round_len, m_len);
        step();
        do_start();

        // Round-length saturation over MAX_LEN+2 wins
        for (int r = 0; r < MAX_LEN + 2; r++) begin
            load_round();
            play_round(0);
        end
        @(negedge CLK);
        chk("sat_round_len", round_len, MAX_LEN);
        chk("sat_score", score, MAX_LEN + 2);
        step();

`ifdef MEMORY_GAME_TIMEOUT_EN
        begin : timeout_case
            exp_t e;
            load_round();
            e = '0;
            lose_life(e);
            fill(e);
            exp_q.push_back(e);
            wait_drain();
            @(negedge CLK);
            chk("timeout_lives", lives_left, m_lives);
            step();
        end
        load_round();
`else
        load_round();
        repeat (2000) step();
        @(negedge CLK);
        chk("no_timeout_pat_ready", pat_ready, 0);
        chk("no_timeout_lives", lives_left, m_lives);
        step();
`endif

        // Reset in PLAY after one correct key
        send_key(m_pats[0]);
        wait_drain();
        #2;
        RST = 1'b1;
        #1;
        chk("midrst_pat_ready", pat_ready, 0);
        chk("midrst_pulses", {hit, miss, round_win}, 0);
        chk("midrst_game_over", game_over, 0);
        chk("midrst_round_len", round_len, 1);
        chk("midrst_score", score, 0);
        chk("midrst_lives", lives_left, LIVES);
        exp_q.delete();
        model_start();
        step();
        RST = 1'b0;
        step();
        key_valid = 1'b1; key_data = 4'h0;
        step();
        key_valid = 1'b0;
        repeat (3) step();
        @(negedge CLK);
        chk("postrst_idle_pat_ready", pat_ready, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_game_checker.md
Name: memory_game_checker

Overview:
- Player-side counterpart to the pattern generator (LFSR, storage and display mux) in the memory game.
- Accepts the round's sequence of 4-bit patterns from the generator through a valid/ready handshake and buffers them.
- Compares each player key entry against the buffered pattern in order.
- Tracks round length, score and lives, and reports hit/miss/round-win pulses and game-over.

Parameters:
- MAX_LEN, 8, maximum patterns per round (1..15).
- LIVES, 3, lives at game start (1..3).
- TIMEOUT_CYCLES, 1024, idle cycles allowed per key in PLAY (used only with the optional feature).

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous active-high reset
- start  input  1  begin/restart game (sampled in IDLE and OVER only)
- pat_valid  input  1  generator presents pat_data
- pat_data  input  4  pattern from generator
- pat_ready  output  1  checker accepts a pattern this cycle
- key_valid  input  1  one-cycle player entry strobe
- key_data  input  4  player entry
- hit  output  1  1-cycle pulse, correct entry
- miss  output  1  1-cycle pulse, wrong entry (or timeout)
- round_win  output  1  1-cycle pulse, full sequence matched
- game_over  output  1  level, high in OVER
- round_len  output  4  patterns in current round
- score  output  8  rounds won, saturating at 255
- lives_left  output  2  remaining lives

Behaviour:
- Reset is asynchronous and active-high on RST; the single clock is CLK.
- Reset values:
  - state = IDLE
  - pat_ready = hit = miss = round_win = game_over = 0
  - round_len = 1, score = 0, lives_left = LIVES
  - write and read pointers = 0
- Reset asserted mid-game aborts immediately to these values.
- Internal buffer: MAX_LEN x 4 bits, write pointer wr_ptr, read pointer rd_ptr.
- FSM states: IDLE, LOAD, PLAY, OVER. state_q is registered; all outputs are registered.
- IDLE:
  - On start: go to LOAD; round_len = 1, score = 0, lives_left = LIVES, wr_ptr = 0.
  - key_valid and pat_valid are ignored.
- LOAD:
  - pat_ready = 1 (registered, asserted the cycle after entry).
  - A transfer occurs on pat_valid && pat_ready: buf[wr_ptr] <= pat_data, wr_ptr++.
  - When the transfer with wr_ptr == round_len-1 completes: pat_ready drops the next cycle, go to PLAY, rd_ptr = 0.
  - key_valid during LOAD is ignored (no pulse).
  - start is ignored.
- PLAY:
  - pat_ready = 0.
  - On key_valid, compare key_data with buf[rd_ptr]. Result pulses appear the cycle after key_valid (1-cycle latency).
  - Match, not last: hit = 1, rd_ptr++.
  - Match with rd_ptr == round_len-1:
    - hit = 1 and round_win = 1 in the same cycle.
    - score increments, saturating at 255.
    - round_len increments, saturating at MAX_LEN (stays MAX_LEN).
    - wr_ptr = 0, go to LOAD.
  - Mismatch:
    - miss = 1, lives_left decrements.
    - If the new lives_left == 0: go to OVER.
    - Otherwise: wr_ptr = 0, go to LOAD with round_len unchanged; the generator supplies a fresh sequence.
  - key_valid on consecutive cycles is legal; each entry is evaluated.
- OVER:
  - game_over = 1; score, round_len and lives_left are held.
  - On start: same actions as start in IDLE; game_over clears the next cycle.
- Pulses are never asserted outside the cycle following a PLAY evaluation.
- Simultaneous pat_valid and key_valid: pat_valid is used only in LOAD and key_valid only in PLAY, so only one takes effect.

Optional Feature:
- Macro: MEMORY_GAME_TIMEOUT_EN.
- Defined:
  - A timer counts cycles in PLAY. It clears on PLAY entry and on every key_valid.
  - When the timer reaches TIMEOUT_CYCLES-1 without key_valid, it is treated exactly as a mismatch: miss pulse, lives decrement, then LOAD or OVER.
  - The timer clears on that event.
- Not defined: no timer logic; PLAY waits indefinitely for key_valid.

Test Plan:
- Reset, then start; generator sends pat_data=4'hA; key 4'hA -> hit and round_win pulse one cycle after the key, score=1, round_len=2, state returns to LOAD with pat_ready=1.
- Round of length 2 with patterns 4'h3, 4'hC; keys 4'h3 then 4'h5 -> hit, then miss; lives_left 3->2, round_len stays 2, back to LOAD.
- Three consecutive misses from LIVES=3 -> lives_left=0, game_over=1, further key_valid produces no pulses; start -> game_over=0, score=0, lives_left=3, round_len=1.
- Win MAX_LEN+2 rounds -> round_len saturates at 8, score increments each win; pat_valid held low mid-LOAD stalls with pat_ready=1 and no state change.
- Assert RST during PLAY after one correct key -> all outputs immediately at reset values, state IDLE; key_valid in LOAD and IDLE -> no hit/miss.
- With MEMORY_GAME_TIMEOUT_EN and TIMEOUT_CYCLES=16: enter PLAY, no key for 16 cycles -> miss pulse, lives_left decremented; without the macro, 2000 idle cycles -> no pulse.
